// File: rtl/ts1n28hpcphvtb256x28m4s_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ts1n28hpcphvtb256x28m4s_if : access port bundle of the 256x28 single-port SRAM
// Rev 1.0
// ----------------------------------------------------------------------------
interface ts1n28hpcphvtb256x28m4s_if #(
    parameter int N = 28,
    parameter int M = 8
);
    logic         CEB;
    logic         WEB;
    logic [M-1:0] A;
    logic [N-1:0] D;
    logic [N-1:0] Q;

    modport master (
        output CEB,
        output WEB,
        output A,
        output D,
        input  Q
    );

    modport slave (
        input  CEB,
        input  WEB,
        input  A,
        input  D,
        output Q
    );
endinterface
`default_nettype wire

// File: rtl/ts1n28hpcphvtb256x28m4s.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ts1n28hpcphvtb256x28m4s : 256x28 single-port synchronous SRAM, registered Q
// Rev 1.0
// ----------------------------------------------------------------------------
module ts1n28hpcphvtb256x28m4s #(
    parameter int N     = 28,
    parameter int M     = 8,
    parameter int DEPTH = 256
) (
    input  wire logic CLK,
    input  wire logic RST,
    ts1n28hpcphvtb256x28m4s_if.slave bus
);
    logic [N-1:0] mem_q [DEPTH];
    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic         w_wr;
    logic         w_rd;

    assign w_wr = !bus.CEB && !bus.WEB;
    assign w_rd = !bus.CEB &&  bus.WEB;

    // Array contents survive reset; RST only gates the access edge.
    always_ff @(posedge CLK) begin
        if (!RST && w_wr) begin
            mem_q[bus.A] <= bus.D;
        end
    end

    always_comb begin
        q_d = q_q;
        if (w_rd) begin
            q_d = mem_q[bus.A];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q = q_q;
endmodule
`default_nettype wire

// File: tb/tb_ts1n28hpcphvtb256x28m4s.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ts1n28hpcphvtb256x28m4s : scoreboard bench for the 256x28 SRAM
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ts1n28hpcphvtb256x28m4s;
    typedef struct {
        bit          known;
        logic [27:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    logic [27:0] mem_m [256];
    bit          known_m [256];
    logic [27:0] q_m;
    bit          q_known;

    ts1n28hpcphvtb256x28m4s_if #(.N(28), .M(8)) bus ();

    ts1n28hpcphvtb256x28m4s #(.N(28), .M(8), .DEPTH(256)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access per call; the model predicts Q after the coming rising edge.
    task automatic cycle(input bit ceb, input bit web, input logic [7:0] a, input logic [27:0] d);
        exp_t e;
        @(negedge clk);
        bus.CEB = ceb;
        bus.WEB = web;
        bus.A   = a;
        bus.D   = d;
        if (!rst && !ceb) begin
            if (!web) begin
                mem_m[a]   = d;
                known_m[a] = 1'b1;
            end else begin
                q_m     = mem_m[a];
                q_known = known_m[a];
            end
        end
        e.known = q_known;
        e.val   = q_m;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [27:0] d);
        cycle(1'b0, 1'b0, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        cycle(1'b0, 1'b1, a, 28'h0);
    endtask

    task automatic idle();
        cycle(1'b1, 1'($urandom), 8'($urandom), 28'($urandom));
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.Q !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: Q=%h required 0000000", bus.Q);
        end
        q_m     = 28'h0;
        q_known = 1'b1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor: Q is presented after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.known) begin
                    checks++;
                    if (bus.Q !== e.val) begin
                        errors++;
                        $display("FAIL q_check t=%0t: Q=%h required %h", $time, bus.Q, e.val);
                    end
                end
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        q_m     = 28'h0;
        q_known = 1'b1;
        for (int i = 0; i < 256; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = 28'h0;
        end
        rst     = 1'b1;
        bus.CEB = 1'b1;
        bus.WEB = 1'b1;
        bus.A   = 8'h0;
        bus.D   = 28'h0;
        #1;
        checks++;
        if (bus.Q !== 28'h0) begin
            errors++;
            $display("FAIL power_up_reset: Q=%h required 0000000", bus.Q);
        end
        repeat (2) @(negedge clk);
        release_reset();

        // Reset clears Q asynchronously and blocks the access edge.
        wr(8'd7, 28'hABCDEF1);
        rd(8'd7);
        idle();
        assert_reset();
        wr(8'd5, 28'h1234567);
        idle();
        release_reset();
        rd(8'd5);
        @(posedge clk);
        #1;
        checks++;
        if (bus.Q === 28'h1234567) begin
            errors++;
            $display("FAIL write_during_reset: Q=%h required not 1234567", bus.Q);
        end

        // Corner addresses and patterns
        wr(8'd0,   28'hFFFFFFF);
        wr(8'd255, 28'h5555555);
        wr(8'd128, 28'hAAAAAAA);
        rd(8'd0);
        rd(8'd255);
        rd(8'd128);

        // No write-through
        wr(8'd3, 28'h0000003);
        rd(8'd3);
        wr(8'd3, 28'h7777777);
        rd(8'd3);

        // Idle hold
        wr(8'd9, 28'h1111111);
        rd(8'd9);
        repeat (10) idle();
        rd(8'd9);
        rd(8'd0);

        // Back-to-back sweep
        for (int i = 0; i < 256; i++) wr(8'(i), 28'(i * 3));
        for (int i = 0; i < 256; i++) rd(8'(i));

        // Reset in the middle of a read sweep
        for (int i = 0; i < 13; i++) rd(8'(i));
        assert_reset();
        rd(8'd40);
        release_reset();
        rd(8'd10);
        rd(8'd200);

        // Random traffic over a small address window
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom_range(0, 15)), 28'($urandom));
        end
        for (int i = 0; i < 16; i++) rd(8'(i));

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
